// File: rtl/addsub_pipe.sv
// Carry-chained add/subtract pipeline: one CHUNK-bit slice per stage, optional signed saturation.
// Latency WIDTH/CHUNK cycles; global stall (out_valid && !out_ready) freezes every stage and drops in_ready.
module addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  input  logic             mode,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int STAGES = WIDTH / CHUNK;

  logic stall;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    // src_a/src_b hold only the operand bits not yet consumed; part_s is the result so far
    localparam int SW = WIDTH - k * CHUNK;
    localparam int PW = (k + 1) * CHUNK;

    logic [SW-1:0]    src_a;
    logic [SW-1:0]    src_b;
    logic             src_c;
    logic             src_v;
    logic             src_sat;
    logic [CHUNK:0]   add;
    logic [PW-1:0]    part_s;

    assign add = {1'b0, src_a[CHUNK-1:0]} + {1'b0, src_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, src_c};

    if (k == 0) begin : g_src
      // Subtraction is folded in here: B is inverted and mode becomes the carry-in
      assign src_a   = inputA;
      assign src_b   = mode ? ~inputB : inputB;
      assign src_c   = mode;
      assign src_v   = in_valid;
      assign src_sat = sat;
      assign part_s  = add[CHUNK-1:0];
    end else begin : g_src
      assign src_a   = g_st[k-1].g_reg.a_q;
      assign src_b   = g_st[k-1].g_reg.b_q;
      assign src_c   = g_st[k-1].g_reg.c_q;
      assign src_v   = g_st[k-1].g_reg.v_q;
      assign src_sat = g_st[k-1].g_reg.sat_q;
      assign part_s  = {add[CHUNK-1:0], g_st[k-1].g_reg.s_q};
    end

    if (k < STAGES - 1) begin : g_reg
      logic [SW-CHUNK-1:0] a_q;
      logic [SW-CHUNK-1:0] b_q;
      logic [PW-1:0]       s_q;
      logic                c_q;
      logic                v_q;
      logic                sat_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q   <= '0;
          b_q   <= '0;
          s_q   <= '0;
          c_q   <= 1'b0;
          v_q   <= 1'b0;
          sat_q <= 1'b0;
        end else if (!stall) begin
          a_q   <= src_a[SW-1:CHUNK];
          b_q   <= src_b[SW-1:CHUNK];
          s_q   <= part_s;
          c_q   <= add[CHUNK];
          v_q   <= src_v;
          sat_q <= src_sat;
        end
      end
    end else begin : g_out
      logic             cout;
      logic             ovf;
      logic [WIDTH-1:0] res;

      // Carry into the MSB is recovered from the MSB operand bits and the raw MSB
      assign cout = add[CHUNK];
      assign ovf  = cout ^ (src_a[CHUNK-1] ^ src_b[CHUNK-1] ^ part_s[WIDTH-1]);
      assign res  = (src_sat && ovf)
                  ? (part_s[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}})
                  : part_s;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid <= 1'b0;
          sum       <= '0;
          carry     <= 1'b0;
          overflow  <= 1'b0;
          zero      <= 1'b0;
          negative  <= 1'b0;
        end else if (!stall) begin
          out_valid <= src_v;
          sum       <= res;
          carry     <= cout;
          overflow  <= ovf;
          zero      <= (res == '0);
          negative  <= res[WIDTH-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed plus random bench for addsub_pipe (WIDTH=16, CHUNK=4) against an integer-arithmetic model.
module tb_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] inputA;
  logic [15:0] inputB;
  logic        mode;
  logic        sat;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        negative;

  addsub_pipe #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .inputA(inputA), .inputB(inputB), .mode(mode), .sat(sat),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry(carry),
    .overflow(overflow), .zero(zero), .negative(negative)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] res;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          chk_lat = 1'b1;
  logic [19:0] last_res = '0;
  logic [19:0] frozen;

  function automatic logic [19:0] model(logic [15:0] a, logic [15:0] b, bit m, bit s);
    int          ia = $signed(a);
    int          ib = $signed(b);
    int          ua = a;
    int          ub = b;
    int          r;
    logic [31:0] rr;
    logic [15:0] res;
    bit          c, o;
    r  = m ? ia - ib : ia + ib;
    rr = r;
    c  = m ? (ua >= ub) : (ua + ub >= 65536);
    o  = (r > 32767) || (r < -32768);
    res = (s && o) ? ((r > 32767) ? 16'h7FFF : 16'h8000) : rr[15:0];
    return {res, c, o, res == 16'h0, res[15]};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Applies inputs for this cycle, then scores whatever the upcoming edge will transfer
  task automatic drive(bit v, logic [15:0] a, logic [15:0] b, bit m, bit s, bit ordy);
    exp_t e;
    in_valid = v; inputA = a; inputB = b; mode = m; sat = s; out_ready = ordy;
    #1;
    if (out_valid) begin
      check("no_spurious_beat", {31'b0, q.size() != 0}, 32'd1);
      if (q.size() != 0 && out_ready) begin
        e = q.pop_front();
        last_res = {sum, carry, overflow, zero, negative};
        check("result", {12'b0, last_res}, {12'b0, e.res});
        if (chk_lat) check("latency", cyc - e.cyc, 32'd4);
      end
    end
    if (v && in_ready) q.push_back('{res: model(a, b, m, s), cyc: cyc});
  endtask

  task automatic step(bit v, logic [15:0] a, logic [15:0] b, bit m, bit s, bit ordy);
    @(negedge clk);
    cyc++;
    drive(v, a, b, m, s, ordy);
  endtask

  task automatic rnd_step(bit ordy);
    step(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy);
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("drain_empty", q.size(), 32'd0);
  endtask

  task automatic directed(string tag, logic [15:0] a, logic [15:0] b, bit m, bit s, logic [19:0] exp);
    step(1'b1, a, b, m, s, 1'b1);
    drain();
    check(tag, {12'b0, last_res}, {12'b0, exp});
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; inputA = '0; inputB = '0; mode = 1'b0; sat = 1'b0; out_ready = 1'b0;
    #1;
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_outputs", {12'b0, sum, carry, overflow, zero, negative}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;

    // First transfer on the first rising edge after release
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc++;
    drive(1'b1, 16'h0102, 16'h0304, 1'b0, 1'b0, 1'b1);
    drain();

    chk_lat = 1'b1;
    directed("add_ovf_nosat", 16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b1});
    directed("add_ovf_sat",   16'h7FFF, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0});
    directed("sub_ovf_sat",   16'h8000, 16'h0001, 1'b1, 1'b1, {16'h8000, 1'b1, 1'b1, 1'b0, 1'b1});
    directed("sub_borrow",    16'h0000, 16'h0001, 1'b1, 1'b0, {16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1});
    directed("sub_zero",      16'h1234, 16'h1234, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    directed("add_wrap",      16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});

    // Ten back-to-back beats: latency check of 4 on each implies consecutive results
    for (int i = 0; i < 10; i++) rnd_step(1'b1);
    drain();

    // Random valid/ready mix with bubbles and stalls
    chk_lat = 1'b0;
    for (int i = 0; i < 60; i++)
      step(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    drain();

    // Fill the pipe with out_ready low, then hold the stall for three cycles
    for (int i = 0; i < 4; i++) rnd_step(1'b0);
    rnd_step(1'b0);
    frozen = {sum, carry, overflow, zero, negative};
    check("stall_out_valid", {31'b0, out_valid}, 32'd1);
    check("stall_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      rnd_step(1'b0);
      check("stall_in_ready_hold", {31'b0, in_ready}, 32'd0);
      check("stall_frozen", {12'b0, sum, carry, overflow, zero, negative}, {12'b0, frozen});
    end
    drain();

    // Asynchronous reset with beats in flight
    chk_lat = 1'b1;
    for (int i = 0; i < 5; i++) rnd_step(1'b1);
    check("pre_reset_out_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("async_reset_outputs", {12'b0, sum, carry, overflow, zero, negative}, 32'd0);
    q.delete();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    cyc++;
    drive(1'b1, 16'h4321, 16'h1111, 1'b1, 1'b0, 1'b1);
    drain();
    check("post_reset_result", {12'b0, last_res}, {12'b0, model(16'h4321, 16'h1111, 1'b1, 1'b0)});
    for (int i = 0; i < 6; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
